quad_combine: RTL and testbench

Final stage of the quadratic solver Y = A*x^2 + B*x + C. It sits directly downstream of the x^2 multiplier and consumes that stage's x^2 stream together with a matching stream carrying the original x. It joins the two streams, forms A*x2 + B*x + C in a 2-stage pipeline with full valid/ready backpressure, and emits Y. It also keeps a wrapping count of results delivered.

---
 rtl/quad_pkg.sv | 10 +
 rtl/quad_combine_stream_join2.sv | 17 +
 rtl/quad_combine.sv | 78 +++++++
 tb/tb_quad_combine.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared types and coefficient defaults for the quadratic solver datapath.
// Imported by the x^2 multiplier and by quad_combine.
package quad_pkg;
  localparam int QUAD_WIDTH = 16;
  localparam logic [QUAD_WIDTH-1:0] QUAD_A = 16'd101;
  localparam logic [QUAD_WIDTH-1:0] QUAD_B = 16'd59;
  localparam logic [QUAD_WIDTH-1:0] QUAD_C = 16'd76;

  typedef logic [QUAD_WIDTH-1:0] quad_word_t;
endpackage

// File: rtl/quad_combine_stream_join2.sv
// Joins two valid/ready streams: a beat is taken from both only when both are
// valid and the consumer can advance, so a lone valid is never consumed.
module stream_join2 (
  input  logic a_valid,
  input  logic b_valid,
  input  logic adv,
  output logic fire,
  output logic a_ready,
  output logic b_ready
);
  // Each ready waits on the other stream's valid so neither side is consumed alone.
  always_comb begin
    fire    = a_valid & b_valid & adv;
    a_ready = adv & b_valid;
    b_ready = adv & a_valid;
  end
endmodule

// File: rtl/quad_combine.sv
// Final quadratic-solver stage: joins the x and x^2 streams and forms
// Y = A*x2 + B*x + C in a 2-stage pipeline with valid/ready backpressure.
module quad_combine
  import quad_pkg::*;
#(
  parameter int WIDTH = QUAD_WIDTH,
  parameter logic [WIDTH-1:0] A = WIDTH'(QUAD_A),
  parameter logic [WIDTH-1:0] B = WIDTH'(QUAD_B),
  parameter logic [WIDTH-1:0] C = WIDTH'(QUAD_C)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x2_data,
  input  logic             x2_valid_in,
  output logic             x2_ready_out,
  input  logic [WIDTH-1:0] x_data,
  input  logic             x_valid_in,
  output logic             x_ready_out,
  output logic [WIDTH-1:0] o_y,
  output logic             o_valid_out,
  input  logic             o_ready_in,
  output logic [WIDTH-1:0] o_count
);
  logic             s1_valid_r;
  logic             s2_valid_r;
  logic [WIDTH-1:0] s1_p_r;
  logic [WIDTH-1:0] s1_q_r;
  logic             adv1_s;
  logic             adv2_s;
  logic             fire_s;

  // A stage may load when it is empty or when the stage after it is draining.
  always_comb begin
    adv2_s = ~s2_valid_r | o_ready_in;
    adv1_s = ~s1_valid_r | adv2_s;
  end

  stream_join2 u_join (
    .a_valid (x_valid_in),
    .b_valid (x2_valid_in),
    .adv     (adv1_s),
    .fire    (fire_s),
    .a_ready (x_ready_out),
    .b_ready (x2_ready_out)
  );

  // Pipeline registers, result register and delivered-result counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      s1_p_r     <= '0;
      s1_q_r     <= '0;
      o_y        <= '0;
      o_count    <= '0;
    end else begin
      if (adv1_s) begin
        s1_valid_r <= fire_s;
        if (fire_s) begin
          s1_p_r <= A * x2_data;
          s1_q_r <= B * x_data + C;
        end
      end
      if (adv2_s) begin
        s2_valid_r <= s1_valid_r;
        // o_y only changes when stage 2 advances, so it holds under backpressure.
        if (s1_valid_r) begin
          o_y <= s1_p_r + s1_q_r;
        end
      end
      if (s2_valid_r & o_ready_in) begin
        o_count <= o_count + WIDTH'(1);
      end
    end
  end

  assign o_valid_out = s2_valid_r;
endmodule

// File: tb/tb_quad_combine.sv
// Directed self-checking bench for quad_combine with hand-computed results.
module tb_quad_combine;
  logic        clk;
  logic        rst;
  logic [15:0] x2_data;
  logic        x2_valid_in;
  logic        x2_ready_out;
  logic [15:0] x_data;
  logic        x_valid_in;
  logic        x_ready_out;
  logic [15:0] o_y;
  logic        o_valid_out;
  logic        o_ready_in;
  logic [15:0] o_count;

  int checks;
  int errors;

  quad_combine dut (
    .clk          (clk),
    .rst          (rst),
    .x2_data      (x2_data),
    .x2_valid_in  (x2_valid_in),
    .x2_ready_out (x2_ready_out),
    .x_data       (x_data),
    .x_valid_in   (x_valid_in),
    .x_ready_out  (x_ready_out),
    .o_y          (o_y),
    .o_valid_out  (o_valid_out),
    .o_ready_in   (o_ready_in),
    .o_count      (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [15:0] x, input logic [15:0] x2);
    x_data = x; x2_data = x2; x_valid_in = 1'b1; x2_valid_in = 1'b1;
  endtask

  task automatic idle();
    x_valid_in = 1'b0; x2_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); o_ready_in = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    x_data = 16'd0; x2_data = 16'd0;
    do_reset();
    #1;
    checks++; if (o_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", o_valid_out); end
    checks++; if (o_y !== 16'd0) begin errors++; $display("FAIL reset_y got %0d exp 0", o_y); end
    checks++; if (o_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", o_count); end
    checks++; if (x_ready_out !== 1'b0 || x2_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b%0b exp 00", x_ready_out, x2_ready_out); end
  endtask

  task automatic test_defaults();
    do_reset();
    offer(16'd3, 16'd9);
    tick(); idle();
    checks++; if (o_valid_out !== 1'b0) begin errors++; $display("FAIL defaults_lat1 got valid %0b exp 0", o_valid_out); end
    tick();
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd1162) begin errors++; $display("FAIL defaults_y got %0b/%0d exp 1/1162", o_valid_out, o_y); end
    tick();
    checks++; if (o_valid_out !== 1'b0 || o_count !== 16'd1) begin errors++; $display("FAIL defaults_count got %0b/%0d exp 0/1", o_valid_out, o_count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] xs  [3] = '{16'd0, 16'd1, 16'd3};
    logic [15:0] x2s [3] = '{16'd0, 16'd1, 16'd9};
    logic [15:0] ys  [3] = '{16'd76, 16'd236, 16'd1162};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) offer(xs[i], x2s[i]); else idle();
      tick();
      if (i >= 1 && i <= 3) begin
        checks++; if (o_valid_out !== 1'b1 || o_y !== ys[i-1]) begin errors++; $display("FAIL b2b_y%0d got %0b/%0d exp 1/%0d", i-1, o_valid_out, o_y, ys[i-1]); end
      end else begin
        checks++; if (o_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_idle%0d got valid %0b exp 0", i, o_valid_out); end
      end
    end
    checks++; if (o_count !== 16'd3) begin errors++; $display("FAIL b2b_count got %0d exp 3", o_count); end
  endtask

  task automatic test_skewed_join();
    do_reset();
    x_data = 16'd1; x_valid_in = 1'b1; x2_data = 16'd1; x2_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (x_ready_out !== 1'b0) begin errors++; $display("FAIL skew_xready%0d got %0b exp 0", i, x_ready_out); end
      tick();
      checks++; if (o_valid_out !== 1'b0) begin errors++; $display("FAIL skew_nooutput%0d got %0b exp 0", i, o_valid_out); end
    end
    x2_valid_in = 1'b1;
    #1;
    checks++; if (x_ready_out !== 1'b1 || x2_ready_out !== 1'b1) begin errors++; $display("FAIL skew_joined got %0b%0b exp 11", x_ready_out, x2_ready_out); end
    tick(); idle();
    checks++; if (o_valid_out !== 1'b0) begin errors++; $display("FAIL skew_lat1 got %0b exp 0", o_valid_out); end
    tick();
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd236) begin errors++; $display("FAIL skew_y got %0b/%0d exp 1/236", o_valid_out, o_y); end
    tick();
    checks++; if (o_valid_out !== 1'b0 || o_count !== 16'd1) begin errors++; $display("FAIL skew_single got %0b/%0d exp 0/1", o_valid_out, o_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    o_ready_in = 1'b0;
    offer(16'd0, 16'd0); #1;
    checks++; if (x_ready_out !== 1'b1) begin errors++; $display("FAIL bp_accept0 got %0b exp 1", x_ready_out); end
    tick();
    offer(16'd1, 16'd1); #1;
    checks++; if (x_ready_out !== 1'b1) begin errors++; $display("FAIL bp_accept1 got %0b exp 1", x_ready_out); end
    tick();
    offer(16'd3, 16'd9); #1;
    checks++; if (x_ready_out !== 1'b0 || x2_ready_out !== 1'b0) begin errors++; $display("FAIL bp_full got %0b%0b exp 00", x_ready_out, x2_ready_out); end
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd76) begin errors++; $display("FAIL bp_head got %0b/%0d exp 1/76", o_valid_out, o_y); end
    tick();
    checks++; if (o_y !== 16'd76 || o_count !== 16'd0) begin errors++; $display("FAIL bp_hold got %0d/%0d exp 76/0", o_y, o_count); end
    o_ready_in = 1'b1; #1;
    checks++; if (x_ready_out !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %0b exp 1", x_ready_out); end
    tick(); idle();
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd236) begin errors++; $display("FAIL bp_y1 got %0b/%0d exp 1/236", o_valid_out, o_y); end
    tick();
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd1162) begin errors++; $display("FAIL bp_y2 got %0b/%0d exp 1/1162", o_valid_out, o_y); end
    tick();
    checks++; if (o_valid_out !== 1'b0 || o_count !== 16'd3) begin errors++; $display("FAIL bp_count got %0b/%0d exp 0/3", o_valid_out, o_count); end
  endtask

  task automatic test_wraparound();
    do_reset();
    offer(16'd250, 16'd62500);
    tick(); idle(); tick();
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd35870) begin errors++; $display("FAIL wrap_y got %0b/%0d exp 1/35870", o_valid_out, o_y); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    offer(16'd0, 16'd0); tick();
    offer(16'd1, 16'd1); tick();
    idle(); rst = 1'b1;
    tick(); rst = 1'b0;
    checks++; if (o_valid_out !== 1'b0 || o_y !== 16'd0 || o_count !== 16'd0) begin errors++; $display("FAIL midrst_clear got %0b/%0d/%0d exp 0/0/0", o_valid_out, o_y, o_count); end
    offer(16'd1, 16'd1); tick(); idle();
    checks++; if (o_valid_out !== 1'b0) begin errors++; $display("FAIL midrst_discard got valid %0b exp 0", o_valid_out); end
    tick();
    checks++; if (o_valid_out !== 1'b1 || o_y !== 16'd236) begin errors++; $display("FAIL midrst_y got %0b/%0d exp 1/236", o_valid_out, o_y); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_defaults();
    test_back_to_back();
    test_skewed_join();
    test_backpressure();
    test_wraparound();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
